// File: rtl/or_arb_pkg.sv
// Shared types and helpers for the pair-OR round-robin LED arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package or_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_t;

    localparam int N_CH = 7;
    localparam int ID_W = 3;

    // Channel i requests when either of its two raw inputs is high.
    function automatic logic [N_CH-1:0] pair_or(input logic [2*N_CH-1:0] raw);
        logic [N_CH-1:0] r;
        for (int i = 0; i < N_CH; i++) begin
            r[i] = raw[2*i] | raw[2*i+1];
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner search starting one past last_id, wrapping at N_CH-1.
// Latency: combinational.
// Backpressure: none; valid is low when no request is set.
module rr_pick
    import or_arb_pkg::*;
(
    input  logic [N_CH-1:0] req,
    input  logic [ID_W-1:0] last_id,
    output logic            valid,
    output logic [ID_W-1:0] id
);

    localparam logic [ID_W:0] NCH_W = (ID_W+1)'(N_CH);

    always_comb begin
        logic [ID_W:0] idx;
        valid = 1'b0;
        id    = '0;
        idx   = '0;
        // Walk offsets 1..N_CH so last_id itself is checked last.
        for (int k = 1; k <= N_CH; k++) begin
            idx = {1'b0, last_id} + (ID_W+1)'(k);
            if (idx >= NCH_W) begin
                idx = idx - NCH_W;
            end
            if (!valid && req[idx[ID_W-1:0]]) begin
                valid = 1'b1;
                id    = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/or_pair_arbiter.sv
// Shares the LED bank among seven pair-OR requesters with round-robin, bounded-hold grants.
// Latency: 2 cycles input to o_led; grant lasts up to HOLD_CYCLES, then 1 gap cycle.
// Backpressure: en low blocks new grants only; a running grant always completes.
module or_pair_arbiter
    import or_arb_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2*N_CH-1:0] in,
    input  logic              en,
    output logic [N_CH:0]     o_led,
    output logic [ID_W-1:0]   o_grant_id,
    output logic              o_busy
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

    arb_state_t      state_q, state_d;
    logic [N_CH-1:0] req_q;
    logic [ID_W-1:0] last_id_q, last_id_d;
    logic [ID_W-1:0] grant_id_q, grant_id_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_CH:0]   led_q, led_d;
    logic            pick_vld;
    logic [ID_W-1:0] pick_id;

    rr_pick u_rr_pick (
        .req     (req_q),
        .last_id (last_id_q),
        .valid   (pick_vld),
        .id      (pick_id)
    );

    always_comb begin
        state_d    = state_q;
        last_id_d  = last_id_q;
        grant_id_d = grant_id_q;
        cnt_d      = cnt_q;
        led_d      = '0;

        case (state_q)
            ST_IDLE, ST_GAP: begin
                state_d = ST_IDLE;
                if (en && pick_vld) begin
                    state_d    = ST_GRANT;
                    grant_id_d = pick_id;
                    last_id_d  = pick_id;
                    cnt_d      = CNT_W'(HOLD_CYCLES - 1);
                end
            end
            ST_GRANT: begin
                // Sampled request decides; a drop releases ahead of the hold limit.
                if (cnt_q == '0 || !req_q[grant_id_q]) begin
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next-state view so they align with state_q.
        if (state_d != ST_IDLE) begin
            led_d[N_CH] = 1'b1;
        end
        if (state_d == ST_GRANT) begin
            led_d[N_CH-1:0] = N_CH'(1) << grant_id_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            last_id_q  <= ID_W'(N_CH - 1);
            grant_id_q <= '0;
            cnt_q      <= '0;
            led_q      <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= pair_or(in);
            last_id_q  <= last_id_d;
            grant_id_q <= grant_id_d;
            cnt_q      <= cnt_d;
            led_q      <= led_d;
        end
    end

    assign o_led      = led_q;
    assign o_grant_id = grant_id_q;
    assign o_busy     = led_q[N_CH];

endmodule
